k_nearest_voter: RTL and testbench
==================================

K_NEAREST_VOTER -- requirements
Module: k_nearest_voter

Interface
REQ-001 Parameter W, default 16: width of distance and class label.
REQ-002 Parameter K, default 3: neighbours kept; SHALL be >= 1.
REQ-003 Parameter T, default 8: training samples per classification; SHALL be >= K.
REQ-004 Parameter C, default 4: number of classes, labels 0..C-1.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  single-cycle pulse; clears the neighbour list and begins a classification.
REQ-008 dist_valid  in  1  one-cycle strobe; distance and data_type are valid this cycle (the upstream done pulse).
REQ-009 distance  in  W  squared distance of one training sample.
REQ-010 data_type  in  W  class label of that sample.
REQ-011 busy  out  1  high from the cycle after start until the cycle result_valid is asserted, inclusive.
REQ-012 result_valid  out  1  one-cycle pulse; result_class is valid.
REQ-013 result_class  out  W  winning class; held until the next result_valid.
REQ-014 sample_drop  out  1  one-cycle pulse when dist_valid arrives outside COLLECT.

Function
REQ-015 States SHALL be IDLE, COLLECT, VOTE and DONE.
REQ-016 IDLE -> COLLECT on start: all K slots set to distance all-ones, label 0, valid 0, and sample count set to 0.
REQ-017 In COLLECT, each dist_valid SHALL insert {distance, data_type} into the ascending sorted list in the same cycle; entries farther away shift down one slot, and slot K-1 is discarded.
REQ-018 Insertion position = first slot whose distance is strictly greater than the new distance, or any invalid slot; equal distances keep earlier arrivals nearer (stable).
REQ-019 A new distance greater than or equal to every valid entry of a full list SHALL leave the list unchanged, but still counts as a sample.
REQ-020 COLLECT -> VOTE on the dist_valid that brings the sample count to T.
REQ-021 VOTE SHALL take exactly C cycles: cycle c counts the valid slots whose label equals c (count width = clog2(K+1)).
REQ-022 Winner = class with the highest count; a tie goes to the lower class index; labels >= C are never counted.
REQ-023 VOTE -> DONE after class C-1; in DONE, result_valid=1 and result_class=winner for one cycle, then DONE -> IDLE.
REQ-024 Latency from the T-th dist_valid to result_valid SHALL be C+1 cycles.
REQ-025 start in COLLECT, VOTE or DONE SHALL abort the current classification and re-enter COLLECT with a cleared list; no result_valid is produced for the aborted run.
REQ-026 start and dist_valid in the same cycle: start wins and the sample is dropped (sample_drop=1).
REQ-027 dist_valid in IDLE, VOTE or DONE SHALL be ignored and SHALL pulse sample_drop.
REQ-028 If all counted entries are 0 (every label >= C), result_class = 0.

Reset
REQ-029 rst SHALL override all inputs, including start.
REQ-030 While rst is high: state=IDLE; busy, result_valid and sample_drop = 0; result_class = 0; slots cleared as in REQ-016; counters = 0.
REQ-031 rst mid-COLLECT or mid-VOTE SHALL discard all partial state; no result_valid follows.

Structure
REQ-032 A shared package knn_pkg SHALL hold the state enum, the DIST_MAX (all-ones) constant and the default W.
REQ-033 One sub-module, knn_slot, SHALL hold one {valid, distance, label} entry and produce its greater-than compare; k_nearest_voter SHALL instantiate K of them plus the shift/insert control.

Verification (W=16, K=3, T=5, C=4)
REQ-034 Distances 50,10,30,20,40 with labels 1,2,2,1,3 -> list 10/2, 20/1, 30/2; result_class=2 exactly C+1=5 cycles after the 5th strobe.
REQ-035 Distances 5,5,5,9,9 with labels 3,1,1,0,0 -> list 5/3, 5/1, 5/1 (stable); result_class=1.
REQ-036 Three-way tie, labels 3,2,1 at distances 1,2,3 with the rest at 100 -> result_class=1 (lowest index).
REQ-037 start pulsed after the 3rd sample, then 5 new samples -> exactly one result_valid, computed only from the new samples.
REQ-038 dist_valid during VOTE -> sample_drop=1, list unchanged, result unaffected; rst mid-VOTE -> no result_valid, busy=0 on the next cycle.

Source files
------------

// File: rtl/knn_pkg.sv
// ============================================================================
// knn_pkg
// Shared types and constants for the k-nearest-neighbour voter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package knn_pkg;

    localparam int DEFAULT_W = 16;

    // Wide all-ones value; users slice the low W bits.
    localparam logic [63:0] DIST_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VOTE    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/knn_slot.sv
// ============================================================================
// knn_slot
// One neighbour entry {valid, distance, label} with a greater-than compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module knn_slot
    import knn_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         valid_d_i,
    input  logic [W-1:0] dist_d_i,
    input  logic [W-1:0] label_d_i,
    input  logic [W-1:0] cmp_dist_i,
    output logic         valid_o,
    output logic [W-1:0] dist_o,
    output logic [W-1:0] label_o,
    output logic         gt_o
);

    logic         valid_q;
    logic [W-1:0] dist_q;
    logic [W-1:0] label_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= 1'b0;
            dist_q  <= DIST_MAX[W-1:0];
            label_q <= '0;
        end else if (load_i) begin
            valid_q <= valid_d_i;
            dist_q  <= dist_d_i;
            label_q <= label_d_i;
        end
    end

    assign valid_o = valid_q;
    assign dist_o  = dist_q;
    assign label_o = label_q;
    assign gt_o    = dist_q > cmp_dist_i;

endmodule

`default_nettype wire

// File: rtl/k_nearest_voter.sv
// ============================================================================
// k_nearest_voter
// Keeps the K nearest of T training samples and votes the majority class.
// Revision: 1.0
// ============================================================================
`default_nettype none

module k_nearest_voter
    import knn_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int K = 3,
    parameter int T = 8,
    parameter int C = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         dist_valid_i,
    input  logic [W-1:0] distance_i,
    input  logic [W-1:0] data_type_i,
    output logic         busy_o,
    output logic         result_valid_o,
    output logic [W-1:0] result_class_o,
    output logic         sample_drop_o
);

    localparam int SCW = $clog2(T + 1);
    localparam int CIW = (C > 1) ? $clog2(C) : 1;
    localparam int VCW = $clog2(K + 1);

    state_t           state_q, state_d;
    logic [SCW-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CIW-1:0]   class_idx_q, class_idx_d;
    logic [VCW-1:0]   best_cnt_q, best_cnt_d;
    logic [CIW-1:0]   best_cls_q, best_cls_d;
    logic [W-1:0]     result_q;
    logic [VCW-1:0]   class_cnt;
    logic             accept;

    logic [K-1:0]     slot_valid;
    logic [K-1:0]     slot_gt;
    logic [K-1:0]     slot_ins;
    logic [W-1:0]     slot_dist  [K];
    logic [W-1:0]     slot_label [K];
    logic [K-1:0]     nxt_valid;
    logic [W-1:0]     nxt_dist   [K];
    logic [W-1:0]     nxt_label  [K];

    assign accept = (state_q == ST_COLLECT) && dist_valid_i && !start_i;

    // slot_ins is monotonic over a sorted list: every slot from the insertion
    // point down takes its upper neighbour, the insertion slot takes the sample.
    for (genvar i = 0; i < K; i++) begin : g_slot
        assign slot_ins[i] = !slot_valid[i] || slot_gt[i];

        if (i == 0) begin : g_head
            assign nxt_valid[i] = 1'b1;
            assign nxt_dist[i]  = distance_i;
            assign nxt_label[i] = data_type_i;
        end else begin : g_tail
            assign nxt_valid[i] = slot_ins[i-1] ? slot_valid[i-1] : 1'b1;
            assign nxt_dist[i]  = slot_ins[i-1] ? slot_dist[i-1]  : distance_i;
            assign nxt_label[i] = slot_ins[i-1] ? slot_label[i-1] : data_type_i;
        end

        knn_slot #(
            .W (W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (start_i),
            .load_i     (accept && slot_ins[i]),
            .valid_d_i  (nxt_valid[i]),
            .dist_d_i   (nxt_dist[i]),
            .label_d_i  (nxt_label[i]),
            .cmp_dist_i (distance_i),
            .valid_o    (slot_valid[i]),
            .dist_o     (slot_dist[i]),
            .label_o    (slot_label[i]),
            .gt_o       (slot_gt[i])
        );
    end

    always_comb begin
        class_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (slot_valid[i] && (slot_label[i] == W'(class_idx_q))) begin
                class_cnt = class_cnt + VCW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        class_idx_d  = class_idx_q;
        best_cnt_d   = best_cnt_q;
        best_cls_d   = best_cls_q;
        case (state_q)
            ST_IDLE: ;
            ST_COLLECT: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + SCW'(1);
                    if (sample_cnt_q == SCW'(T - 1)) begin
                        state_d     = ST_VOTE;
                        class_idx_d = '0;
                        best_cnt_d  = '0;
                        best_cls_d  = '0;
                    end
                end
            end
            ST_VOTE: begin
                // Strict compare keeps the lower class on a tie.
                if (class_cnt > best_cnt_q) begin
                    best_cnt_d = class_cnt;
                    best_cls_d = class_idx_q;
                end
                class_idx_d = class_idx_q + CIW'(1);
                if (class_idx_q == CIW'(C - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (start_i) begin
            state_d      = ST_COLLECT;
            sample_cnt_d = '0;
            class_idx_d  = '0;
            best_cnt_d   = '0;
            best_cls_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            class_idx_q  <= '0;
            best_cnt_q   <= '0;
            best_cls_q   <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            class_idx_q  <= class_idx_d;
            best_cnt_q   <= best_cnt_d;
            best_cls_q   <= best_cls_d;
            if (result_valid_o) begin
                result_q <= W'(best_cls_q);
            end
        end
    end

    assign busy_o         = !rst && (state_q != ST_IDLE);
    assign result_valid_o = !rst && !start_i && (state_q == ST_DONE);
    assign sample_drop_o  = !rst && dist_valid_i && (start_i || (state_q != ST_COLLECT));
    assign result_class_o = rst            ? '0 :
                            result_valid_o ? W'(best_cls_q) : result_q;

endmodule

`default_nettype wire

// File: tb/tb_k_nearest_voter.sv
// ============================================================================
// tb_k_nearest_voter
// Directed and randomized checks of k_nearest_voter against a sort-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_k_nearest_voter;

    localparam int W = 16;
    localparam int K = 3;
    localparam int T = 5;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         dist_valid_i;
    logic [W-1:0] distance_i;
    logic [W-1:0] data_type_i;
    logic         busy_o;
    logic         result_valid_o;
    logic [W-1:0] result_class_o;
    logic         sample_drop_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] sd [T];
    logic [W-1:0] sl [T];

    always #5 clk = ~clk;

    k_nearest_voter #(
        .W (W),
        .K (K),
        .T (T),
        .C (C)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .dist_valid_i   (dist_valid_i),
        .distance_i     (distance_i),
        .data_type_i    (data_type_i),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_class_o (result_class_o),
        .sample_drop_o  (sample_drop_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // K nearest by (distance, arrival order), then plurality vote over labels < C.
    function automatic int model_class();
        bit used [T];
        int cnt  [C];
        int best;
        for (int i = 0; i < T; i++) used[i] = 1'b0;
        for (int c = 0; c < C; c++) cnt[c] = 0;
        for (int k = 0; k < K; k++) begin
            int b = -1;
            for (int i = 0; i < T; i++) begin
                if (!used[i] && (b < 0 || sd[i] < sd[b])) b = i;
            end
            used[b] = 1'b1;
            if (sl[b] < C) cnt[sl[b]]++;
        end
        best = 0;
        for (int c = 1; c < C; c++) if (cnt[c] > cnt[best]) best = c;
        return best;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start_i      = 1'b1;
        dist_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        #1 chk("busy_after_start", busy_o, 1);
    endtask

    // Leaves the last strobe asserted; the caller's next negedge drops it.
    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap)) begin
                @(negedge clk);
                dist_valid_i = 1'b0;
            end
            @(negedge clk);
            dist_valid_i = 1'b1;
            distance_i   = sd[i];
            data_type_i  = sl[i];
            #1;
            chk("drop_in_collect", sample_drop_o, 0);
            chk("rv_in_collect", result_valid_o, 0);
        end
    endtask

    task automatic expect_result(input int exp_cls, input bit poke);
        for (int k = 1; k <= C + 1; k++) begin
            @(negedge clk);
            dist_valid_i = poke && (k == 2);
            distance_i   = '0;
            data_type_i  = 16'd3;
            #1;
            if (k <= C) chk("rv_low_in_vote", result_valid_o, 0);
            if (poke && k == 2) chk("drop_in_vote", sample_drop_o, 1);
        end
        chk("result_valid", result_valid_o, 1);
        chk("result_class", result_class_o, exp_cls);
        chk("busy_in_done", busy_o, 1);
        @(negedge clk);
        dist_valid_i = 1'b0;
        #1;
        chk("rv_one_cycle", result_valid_o, 0);
        chk("busy_back_idle", busy_o, 0);
        chk("class_held", result_class_o, exp_cls);
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b1;
        dist_valid_i = 1'b1;
        distance_i   = '0;
        data_type_i  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_rv", result_valid_o, 0);
        chk("rst_drop", sample_drop_o, 0);
        chk("rst_class", result_class_o, 0);
        @(negedge clk);
        rst          = 1'b0;
        start_i      = 1'b0;
        dist_valid_i = 1'b0;
        @(negedge clk);
        #1 chk("idle_after_rst", busy_o, 0);

        @(negedge clk);
        dist_valid_i = 1'b1;
        #1 chk("drop_in_idle", sample_drop_o, 1);
        @(negedge clk);
        dist_valid_i = 1'b0;
        #1 chk("idle_stays", busy_o, 0);

        // Basic sort and vote, exact latency
        sd = '{16'd50, 16'd10, 16'd30, 16'd20, 16'd40};
        sl = '{16'd1, 16'd2, 16'd2, 16'd1, 16'd3};
        pulse_start();
        feed(T, 0);
        expect_result(2, 1'b0);

        // Stable ordering among equal distances
        sd = '{16'd5, 16'd5, 16'd5, 16'd9, 16'd9};
        sl = '{16'd3, 16'd1, 16'd1, 16'd0, 16'd0};
        pulse_start();
        feed(T, 1);
        expect_result(1, 1'b0);

        // Three-way tie with a dropped sample during VOTE
        sd = '{16'd1, 16'd2, 16'd3, 16'd100, 16'd100};
        sl = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
        pulse_start();
        feed(T, 2);
        expect_result(1, 1'b1);

        // start with a simultaneous strobe: the strobe is dropped
        @(negedge clk);
        start_i      = 1'b1;
        dist_valid_i = 1'b1;
        distance_i   = '0;
        data_type_i  = 16'd3;
        #1 chk("drop_with_start", sample_drop_o, 1);
        @(negedge clk);
        start_i      = 1'b0;
        dist_valid_i = 1'b0;
        sd = '{16'd50, 16'd10, 16'd30, 16'd20, 16'd40};
        sl = '{16'd1, 16'd2, 16'd2, 16'd1, 16'd3};
        feed(T, 0);
        expect_result(2, 1'b0);

        // Abort after three samples; only the new run is voted
        sd = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        sl = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
        pulse_start();
        feed(3, 1);
        pulse_start();
        sd = '{16'd7, 16'd3, 16'd9, 16'd4, 16'd8};
        sl = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd0};
        feed(T, 1);
        expect_result(1, 1'b0);

        // Reset in the middle of VOTE
        pulse_start();
        feed(T, 0);
        @(negedge clk);
        dist_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("busy_after_vote_rst", busy_o, 0);
        for (int k = 0; k < C + 3; k++) begin
            @(negedge clk);
            #1 chk("no_rv_after_rst", result_valid_o, 0);
        end

        // Randomized classifications
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < T; i++) begin
                sd[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
                sl[i] = 16'($urandom_range(0, 5));
            end
            pulse_start();
            feed(T, 2);
            expect_result(model_class(), ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
